sram_scan_sequencer: RTL

- On-chip sequencer for the SRAM test scan chain. Drives the same serial protocol a bench otherwise drives over GPIO (scan, sram_load, global_csb, serial in/out).
- Accepts one parallel dual-port command per valid/ready handshake, serialises it MSB-first into the 112-bit scan register and fires a one-cycle SRAM access.
- For reads, captures dout, loads it into the scan register, shifts the packet back out and returns it on a valid/ready response channel.
- Sits between an LA/Wishbone-side requester and the scan-chain/SRAM-select logic in the testchip.

---
 rtl/sram_scan_pkg.sv | 82 ++++++++
 rtl/scan_shift_reg.sv | 43 ++++
 rtl/sram_scan_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sram_scan_pkg.sv
// Shared widths, packet field offsets, sequencer states and pack/unpack helpers
// for the SRAM test scan-chain sequencer.
package sram_scan_pkg;

   localparam int SEL_W   = 4;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;
   localparam int WMASK_W = 4;
   localparam int PORT_W  = ADDR_W + DATA_W + 2 + WMASK_W;
   localparam int PKT_W   = SEL_W + 2 * PORT_W;

   // Packet is {sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1}, MSB first
   localparam int WMASK1_LSB = 0;
   localparam int WEB1_BIT   = WMASK_W;
   localparam int CSB1_BIT   = WMASK_W + 1;
   localparam int DIN1_LSB   = WMASK_W + 2;
   localparam int ADDR1_LSB  = DIN1_LSB + DATA_W;
   localparam int WMASK0_LSB = PORT_W;
   localparam int WEB0_BIT   = PORT_W + WEB1_BIT;
   localparam int CSB0_BIT   = PORT_W + CSB1_BIT;
   localparam int DIN0_LSB   = PORT_W + DIN1_LSB;
   localparam int ADDR0_LSB  = PORT_W + ADDR1_LSB;
   localparam int SEL_LSB    = 2 * PORT_W;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHIFT_IN  = 3'd1,
      S_ACCESS    = 3'd2,
      S_CAPTURE   = 3'd3,
      S_LOAD      = 3'd4,
      S_SHIFT_OUT = 3'd5,
      S_RESP      = 3'd6
   } scan_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  din;
      logic               csb;
      logic               web;
      logic [WMASK_W-1:0] wmask;
   } scan_port_t;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      scan_port_t       p0;
      scan_port_t       p1;
   } scan_cmd_t;

   function automatic logic [PKT_W-1:0] pack_cmd(input scan_cmd_t c);
      logic [PKT_W-1:0] p;
      p = '0;
      p[SEL_LSB    +: SEL_W]   = c.sel;
      p[ADDR0_LSB  +: ADDR_W]  = c.p0.addr;
      p[DIN0_LSB   +: DATA_W]  = c.p0.din;
      p[CSB0_BIT]              = c.p0.csb;
      p[WEB0_BIT]              = c.p0.web;
      p[WMASK0_LSB +: WMASK_W] = c.p0.wmask;
      p[ADDR1_LSB  +: ADDR_W]  = c.p1.addr;
      p[DIN1_LSB   +: DATA_W]  = c.p1.din;
      p[CSB1_BIT]              = c.p1.csb;
      p[WEB1_BIT]              = c.p1.web;
      p[WMASK1_LSB +: WMASK_W] = c.p1.wmask;
      return p;
   endfunction

   function automatic scan_cmd_t unpack_cmd(input logic [PKT_W-1:0] p);
      scan_cmd_t c;
      c.sel      = p[SEL_LSB    +: SEL_W];
      c.p0.addr  = p[ADDR0_LSB  +: ADDR_W];
      c.p0.din   = p[DIN0_LSB   +: DATA_W];
      c.p0.csb   = p[CSB0_BIT];
      c.p0.web   = p[WEB0_BIT];
      c.p0.wmask = p[WMASK0_LSB +: WMASK_W];
      c.p1.addr  = p[ADDR1_LSB  +: ADDR_W];
      c.p1.din   = p[DIN1_LSB   +: DATA_W];
      c.p1.csb   = p[CSB1_BIT];
      c.p1.web   = p[WEB1_BIT];
      c.p1.wmask = p[WMASK1_LSB +: WMASK_W];
      return c;
   endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, serial-in/serial-out MSB-first shift register with a shift
// counter that flags the last bit of a packet.
module scan_shift_reg
   import sram_scan_pkg::*;
#(
   parameter int  WIDTH = PKT_W,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             clr,
   input  logic             shift,
   input  logic             serial_in,
   output logic             serial_out,
   output logic [WIDTH-1:0] captured,
   output logic             done
);

   logic [WIDTH-1:0] data;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data <= '0;
         cnt  <= '0;
      end else if (load) begin
         data <= load_data;
         cnt  <= '0;
      end else begin
         if (shift) data <= {data[WIDTH-2:0], serial_in};
         if (clr) cnt <= '0;
         else if (shift && !done) cnt <= cnt + 1'b1;
      end
   end

   assign done       = (cnt == CNT_W'(WIDTH - 1));
   assign serial_out = data[WIDTH-1];
   // Value the register will hold after the current shift completes
   assign captured   = {data[WIDTH-2:0], serial_in};

endmodule

// File: rtl/sram_scan_sequencer.sv
// Scan-chain sequencer: serialises a dual-port SRAM command, fires one access and
// scans read results back out. Define SCAN_LOOPBACK_CHECK_EN to enable rsp_err.
module sram_scan_sequencer
   import sram_scan_pkg::*;
#(
   parameter int  SEL_WIDTH   = SEL_W,
   parameter int  ADDR_WIDTH  = ADDR_W,
   parameter int  DATA_WIDTH  = DATA_W,
   parameter int  WMASK_WIDTH = WMASK_W,
   localparam int PKT_WIDTH   = SEL_WIDTH + 2 * (ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_read,
   input  logic [PKT_WIDTH-1:0] req_pkt,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [PKT_WIDTH-1:0] rsp_pkt,
   output logic                 rsp_err,
   output logic                 scan_out,
   input  logic                 scan_in,
   output logic                 scan_en,
   output logic                 sram_load,
   output logic                 global_csb,
   output logic                 busy
);

   localparam logic [2:0] IDLE      = S_IDLE;
   localparam logic [2:0] SHIFT_IN  = S_SHIFT_IN;
   localparam logic [2:0] ACCESS    = S_ACCESS;
   localparam logic [2:0] CAPTURE   = S_CAPTURE;
   localparam logic [2:0] LOAD      = S_LOAD;
   localparam logic [2:0] SHIFT_OUT = S_SHIFT_OUT;
   localparam logic [2:0] RESP      = S_RESP;

   logic [2:0]           state, state_nxt;
   logic                 cmd_read, accept, sr_done, sr_serial_out;
   logic [PKT_WIDTH-1:0] sr_captured;

   assign accept = (state == IDLE) && req_valid && req_ready;

   // The MSB goes straight to scan_out at accept, so the register holds the rest pre-shifted
   scan_shift_reg #(.WIDTH(PKT_WIDTH)) u_shift (
      .clk        (clk),
      .resetn     (resetn),
      .load       (accept),
      .load_data  ({req_pkt[PKT_WIDTH-2:0], 1'b0}),
      .clr        (state_nxt != state),
      .shift      ((state == SHIFT_IN) || (state == SHIFT_OUT)),
      .serial_in  (scan_in),
      .serial_out (sr_serial_out),
      .captured   (sr_captured),
      .done       (sr_done)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = SHIFT_IN;
         SHIFT_IN:  if (sr_done) state_nxt = ACCESS;
         ACCESS:    state_nxt = cmd_read ? CAPTURE : IDLE;
         CAPTURE:   state_nxt = LOAD;
         LOAD:      state_nxt = SHIFT_OUT;
         SHIFT_OUT: if (sr_done) state_nxt = RESP;
         RESP:      if (rsp_ready) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cmd_read   <= 1'b0;
         req_ready  <= 1'b0;
         busy       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_pkt    <= '0;
         scan_out   <= 1'b0;
         scan_en    <= 1'b0;
         sram_load  <= 1'b0;
         global_csb <= 1'b1;
      end else begin
         state      <= state_nxt;
         req_ready  <= (state_nxt == IDLE);
         busy       <= (state_nxt != IDLE);
         scan_en    <= (state_nxt == SHIFT_IN) || (state_nxt == SHIFT_OUT);
         sram_load  <= (state_nxt == LOAD);
         global_csb <= (state_nxt != ACCESS);
         if (accept) cmd_read <= req_read;

         if (accept) scan_out <= req_pkt[PKT_WIDTH-1];
         else if ((state == SHIFT_IN) && !sr_done) scan_out <= sr_serial_out;
         else scan_out <= 1'b0;

         if ((state == SHIFT_OUT) && sr_done) begin
            rsp_pkt   <= sr_captured;
            rsp_valid <= 1'b1;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef SCAN_LOOPBACK_CHECK_EN
   localparam int PORT_WIDTH = ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH;
   localparam int DIN1_POS   = WMASK_WIDTH + 2;
   localparam int DIN0_POS   = PORT_WIDTH + DIN1_POS;
   localparam logic [PKT_WIDTH-1:0] DATA_ONES = PKT_WIDTH'({DATA_WIDTH{1'b1}});
   localparam logic [PKT_WIDTH-1:0] CTRL_MASK = ~((DATA_ONES << DIN0_POS) | (DATA_ONES << DIN1_POS));

   logic [PKT_WIDTH-1:0] cmd_pkt;

   // Everything except the din fields must survive the round trip through the chain
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_pkt <= '0;
         rsp_err <= 1'b0;
      end else begin
         if (accept) cmd_pkt <= req_pkt;
         if ((state == SHIFT_OUT) && sr_done)
            rsp_err <= ((sr_captured & CTRL_MASK) !== (cmd_pkt & CTRL_MASK));
         else if ((state == RESP) && rsp_ready)
            rsp_err <= 1'b0;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule
